// File: rtl/serial_nibble_deserializer.sv
// Framed serial-to-parallel receiver: start(0), WIDTH data bits LSB first, stop(1).
// Good frames load o_Y and pulse o_valid; a bad stop bit pulses o_err instead.
module serial_nibble_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_A,
  output logic [WIDTH-1:0] o_Y,
  output logic             o_valid,
  output logic             o_err,
  output logic             o_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_sh, w_sh_nxt;
  logic [WIDTH-1:0] r_y, w_y_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_err, w_err_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sh    <= w_sh_nxt;
      r_y     <= w_y_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Pulses default low so they last exactly one cycle, including when enable drops.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_sh;
    w_y_nxt     = r_y;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    if (i_enable) begin
      unique case (r_state)
        S_IDLE: begin
          if (!i_A) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = '0;
          end
        end
        S_DATA: begin
          w_sh_nxt[r_cnt] = i_A;
          if (r_cnt == LAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (i_A) begin
            w_y_nxt     = r_sh;
            w_valid_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign o_Y     = r_y;
  assign o_valid = r_valid;
  assign o_err   = r_err;
  assign o_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_nibble_deserializer.sv
// Directed bench for serial_nibble_deserializer with hand-computed expectations.
module tb_serial_nibble_deserializer;

  logic       i_clk = 1'b0;
  logic       i_reset, i_enable, i_A;
  logic [3:0] o_Y;
  logic       o_valid, o_err, o_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_nibble_deserializer #(.WIDTH(4)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_enable(i_enable),
    .i_A     (i_A),
    .o_Y     (o_Y),
    .o_valid (o_valid),
    .o_err   (o_err),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one edge's worth of inputs, then sample 1ns after the edge.
  task automatic step(input logic en, input logic a);
    i_enable = en;
    i_A      = a;
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic frame(input logic [3:0] d, input logic stop);
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, d[i]);
    step(1'b1, stop);
  endtask

  initial begin
    logic [5:0] bits;
    int v1, v2;
    i_reset = 1'b1; i_enable = 1'b0; i_A = 1'b1;

    // 1: reset
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("rst_y", o_Y, 4'h0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    i_reset = 1'b0;

    // 2: good frame 1101, busy through edges 1..5
    bits = 6'b111010; // sent LSB first: 0,1,0,1,1,1
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bits[i]);
      chk("t2_busy", o_busy, 1'b1);
      chk("t2_novalid", o_valid, 1'b0);
    end
    step(1'b1, bits[5]);
    chk("t2_y", o_Y, 4'b1101);
    chk("t2_valid", o_valid, 1'b1);
    chk("t2_err", o_err, 1'b0);
    chk("t2_busy_end", o_busy, 1'b0);
    step(1'b1, 1'b1);
    chk("t2_pulse1", o_valid, 1'b0);

    // 3: enable gap between d1 and d2; pulse on 8th edge
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("t3_hold_busy", o_busy, 1'b1);
    step(1'b0, 1'b1);
    chk("t3_hold_busy2", o_busy, 1'b1);
    chk("t3_hold_valid", o_valid, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("t3_pre_valid", o_valid, 1'b0);
    step(1'b1, 1'b1);
    chk("t3_valid", o_valid, 1'b1);
    chk("t3_y", o_Y, 4'b1101);
    step(1'b1, 1'b1);

    // 4: bad stop bit
    frame(4'h0, 1'b0);
    chk("t4_err", o_err, 1'b1);
    chk("t4_valid", o_valid, 1'b0);
    chk("t4_y", o_Y, 4'b1101);
    step(1'b1, 1'b1);
    chk("t4_err_drop", o_err, 1'b0);

    // 5: reset mid-frame, then 0100
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    i_reset = 1'b1;
    step(1'b1, 1'b1);
    i_reset = 1'b0;
    chk("t5_rst_busy", o_busy, 1'b0);
    chk("t5_rst_y", o_Y, 4'h0);
    step(1'b1, 1'b1);
    chk("t5_nopulse_v", o_valid, 1'b0);
    chk("t5_nopulse_e", o_err, 1'b0);
    frame(4'b0100, 1'b1);
    chk("t5_valid", o_valid, 1'b1);
    chk("t5_y", o_Y, 4'b0100);

    // 6: back-to-back 3 then A
    frame(4'h3, 1'b1);
    chk("t6_v1", o_valid, 1'b1);
    chk("t6_y1", o_Y, 4'h3);
    v1 = cyc;
    frame(4'hA, 1'b1);
    chk("t6_v2", o_valid, 1'b1);
    chk("t6_y2", o_Y, 4'hA);
    chk("t6_err", o_err, 1'b0);
    v2 = cyc;
    chk("t6_period", v2 - v1, 6);

    // 7: idle line
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1);
      chk("t7_busy", o_busy, 1'b0);
      chk("t7_flags", {o_valid, o_err}, 2'b00);
    end
    chk("t7_y", o_Y, 4'hA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
